regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//  Read-side initiator for the register file: on a start command, walks an inclusive
//  address range over the regfile read port and streams each word out on a
//  valid/ready interface for debug dump, context save or scan-out.
//  Connects to one combinational regfile read port (address out, data in, same cycle).
// PARAMETERS
//  WIDTH   32                data word width; must match the regfile
//  DEPTH   32                regfile entries; ADDR_W = $clog2(DEPTH)
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous, active-low reset
//  start        in   1       dump request; sampled only when busy=0
//  first_addr   in   ADDR_W  first address of range; latched on accepted start
//  last_addr    in   ADDR_W  last address of range (inclusive); latched on accepted start
//  busy         out  1       dump in progress
//  done         out  1       one-cycle pulse after the final beat handshakes
//  rf_rd_addr   out  ADDR_W  regfile read address
//  rf_rd_data   in   WIDTH   regfile read data (combinational from rf_rd_addr)
//  m_valid      out  1       output beat valid
//  m_ready      in   1       consumer ready
//  m_data       out  WIDTH   beat data
//  m_addr       out  ADDR_W  regfile address of m_data
//  m_last       out  1       final beat of dump
//  m_csum       out  1       beat is checksum (constant 0 without REGDUMP_CSUM_EN)
// BEHAVIOUR
//  - Reset (rst=0 at clk edge): busy, done, m_valid, m_last, m_csum, m_data, m_addr,
//    rf_rd_addr all 0; FSM -> IDLE. Mid-dump reset aborts; pending beat is discarded.
//  - FSM: IDLE -> RUN on start&!busy; RUN -> CSUM (macro on) or IDLE after last data
//    beat handshakes; CSUM -> IDLE on checksum beat handshake.
//  - Range: count = ((last_addr - first_addr) mod DEPTH) + 1; addresses increment
//    modulo DEPTH, so last<first wraps (30..1 -> 30,31,0,1). first==last: one beat.
//  - RUN: rf_rd_addr = current address register; rf_rd_data captured into the output
//    register whenever (!m_valid | m_ready) and words remain; address then increments.
//  - Latency: m_valid rises on the clock edge after the edge accepting start.
//    Throughput: 1 beat/cycle while m_ready=1.
//  - Handshake: beat transfers on m_valid&m_ready. While m_valid&!m_ready,
//    m_data/m_addr/m_last/m_csum hold stable. m_valid never drops without a transfer
//    (except reset). No beat dropped or duplicated.
//  - busy=1 from start-accept edge through the final handshake edge; done=1 for exactly
//    the cycle following that edge; busy=0 in that cycle. start while busy is ignored;
//    start in the done cycle is accepted.
//  - Simultaneous final handshake and start: impossible (busy=1); no queuing.
// CONFIGURATION
//  REGDUMP_CSUM_EN defined: running XOR of all data beats (cleared on start); one extra
//   beat follows the data beats: m_data=XOR, m_addr=0, m_csum=1, m_last=1 (m_last is
//   then 0 on the last data beat); done follows the checksum handshake.
//  Undefined: no checksum logic, m_csum tied 0, m_last on last data beat.
// TESTING (bench models a DEPTH=32 regfile, entry i = 0x100+i, entry 0 = 0)
//  1. first=1,last=4,m_ready=1 -> 4 beats on consecutive cycles, addr 1..4, data
//     0x101..0x104, m_last on addr 4, done one cycle, busy low with done.
//  2. Same range, m_ready pattern 1,0,0,1,0,1,1 -> beats in order, outputs stable
//     while stalled, exactly 4 transfers.
//  3. first=30,last=1 -> addrs 30,31,0,1; data 0x11E,0x11F,0x000,0x101.
//  4. first=last=5 -> single beat 0x105 with m_last=1; start pulsed mid-dump ignored.
//  5. rst=0 after 2nd beat of 1..4 -> next cycle m_valid=0,busy=0,done=0; new start
//     first=7,last=8 yields 0x107,0x108 only.
//  6. REGDUMP_CSUM_EN, entries 1..3 = 0x11,0x22,0x44 -> 4th beat m_data=0x77,
//     m_csum=1, m_last=1, m_addr=0; done after it.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks an inclusive, wrapping address range over a
// combinational regfile read port and streams each word on a valid/ready
// output for debug dump, context save or scan-out.
// Optional build macro: REGDUMP_CSUM_EN appends one XOR checksum beat.
module regfile_dump_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [WIDTH-1:0]  rf_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last,
  output logic              m_csum
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CSUM = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                m_valid_q, m_valid_d;
  logic [WIDTH-1:0]    m_data_q, m_data_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic                m_last_q, m_last_d;
`ifdef REGDUMP_CSUM_EN
  logic                m_csum_q, m_csum_d;
  logic [WIDTH-1:0]    csum_q, csum_d;
`endif

  logic [ADDR_W:0]     span;
  logic [ADDR_W-1:0]   next_addr;
  logic                refill;

  // Word count of the requested range, wrapping modulo DEPTH when last < first.
  always_comb begin
    span = '0;
    if (last_addr >= first_addr) begin
      span = {1'b0, last_addr} - {1'b0, first_addr} + CNT_ONE;
    end else begin
      span = {1'b0, last_addr} + DEPTH_W - {1'b0, first_addr} + CNT_ONE;
    end
  end

  assign next_addr = (addr_q == ADDR_MAX) ? '0 : addr_q + ADDR_ONE;

  // Output register can take a new word when empty or being drained this cycle.
  assign refill = (!m_valid_q || m_ready) && (remain_q != '0);

  // Next-state logic for the walk FSM, address walker and output beat register.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_addr_d  = m_addr_q;
    m_last_d  = m_last_q;
`ifdef REGDUMP_CSUM_EN
    m_csum_d  = m_csum_q;
    csum_d    = csum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start && !busy_q) begin
          state_d  = ST_RUN;
          busy_d   = 1'b1;
          addr_d   = first_addr;
          remain_d = span;
`ifdef REGDUMP_CSUM_EN
          csum_d   = '0;
`endif
        end
      end
      ST_RUN: begin
        if (refill) begin
          m_valid_d = 1'b1;
          m_data_d  = rf_rd_data;
          m_addr_d  = addr_q;
          remain_d  = remain_q - CNT_ONE;
          addr_d    = next_addr;
`ifdef REGDUMP_CSUM_EN
          // The checksum beat carries the last flag, never a data beat.
          m_last_d  = 1'b0;
          csum_d    = csum_q ^ rf_rd_data;
`else
          m_last_d  = (remain_q == CNT_ONE);
`endif
        end else if (m_valid_q && m_ready) begin
`ifdef REGDUMP_CSUM_EN
          // Final data beat leaves; replace it with the checksum beat.
          m_data_d  = csum_q;
          m_addr_d  = '0;
          m_last_d  = 1'b1;
          m_csum_d  = 1'b1;
          state_d   = ST_CSUM;
`else
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
`endif
        end
      end
      ST_CSUM: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
`ifdef REGDUMP_CSUM_EN
          m_csum_d  = 1'b0;
`endif
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_addr_q  <= '0;
      m_last_q  <= 1'b0;
`ifdef REGDUMP_CSUM_EN
      m_csum_q  <= 1'b0;
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_addr_q  <= m_addr_d;
      m_last_q  <= m_last_d;
`ifdef REGDUMP_CSUM_EN
      m_csum_q  <= m_csum_d;
      csum_q    <= csum_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rf_rd_addr = addr_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_addr     = m_addr_q;
  assign m_last     = m_last_q;
`ifdef REGDUMP_CSUM_EN
  assign m_csum     = m_csum_q;
`else
  assign m_csum     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: DEPTH=32 regfile model, directed and
// randomized dumps checked against an expected-beat queue built from the
// range rules.
module tb_regfile_dump_reader;

`ifdef REGDUMP_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic        busy;
  logic        done;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [4:0]  m_addr;
  logic        m_last;
  logic        m_csum;

  logic [31:0] rf [32];
  int n_vec = 0;
  int n_err = 0;
  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  assign rf_rd_data = rf[rf_rd_addr];

  regfile_dump_reader #(.WIDTH(32), .DEPTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .busy       (busy),
    .done       (done),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_addr     (m_addr),
    .m_last     (m_last),
    .m_csum     (m_csum)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_default_rf();
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
  endtask

  // Runs one dump starting at the current falling edge; returns at the done cycle.
  // mode 0: always ready, 1: fixed stall pattern, 2: random ready.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                          input bit mid_start);
    logic [31:0] q_data[$];
    logic [4:0]  q_addr[$];
    logic        q_last[$];
    logic        q_csum[$];
    int          cnt;
    int          cyc;
    logic [31:0] x;
    logic [4:0]  a;
    bit          held, expect_done, finished;
    logic [31:0] h_data;
    logic [4:0]  h_addr;
    logic        h_last, h_csum;

    cnt = ((int'(l) - int'(f) + 32) % 32) + 1;
    x = 32'h0;
    for (int i = 0; i < cnt; i++) begin
      a = 5'((int'(f) + i) % 32);
      q_addr.push_back(a);
      q_data.push_back(rf[a]);
      q_last.push_back((i == cnt - 1) && !CSUM_ON);
      q_csum.push_back(1'b0);
      x = x ^ rf[a];
    end
    if (CSUM_ON) begin
      q_addr.push_back(5'd0);
      q_data.push_back(x);
      q_last.push_back(1'b1);
      q_csum.push_back(1'b1);
    end

    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("accept_busy", 64'(busy), 64'd1);
    chk("accept_done_low", 64'(done), 64'd0);
    chk("accept_no_valid", 64'(m_valid), 64'd0);

    cyc = 0;
    held = 1'b0;
    expect_done = 1'b0;
    finished = 1'b0;
    h_data = '0; h_addr = '0; h_last = 1'b0; h_csum = 1'b0;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = mid_start && (cyc == 1);
      if (mid_start && cyc == 1) begin
        first_addr = f + 5'd3;
        last_addr  = f + 5'd9;
      end
      if (expect_done) begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy_low", 64'(busy), 64'd0);
        chk("done_valid_low", 64'(m_valid), 64'd0);
        finished = 1'b1;
      end else begin
        chk("no_early_done", 64'(done), 64'd0);
        if (cyc == 1) chk("first_beat_latency", 64'(m_valid), 64'd1);
        if (held) begin
          chk("stall_valid", 64'(m_valid), 64'd1);
          chk("stall_data", 64'(m_data), 64'(h_data));
          chk("stall_addr", 64'(m_addr), 64'(h_addr));
          chk("stall_last", 64'(m_last), 64'(h_last));
          chk("stall_csum", 64'(m_csum), 64'(h_csum));
        end
        if (mode == 0) chk("throughput_valid", 64'(m_valid), 64'd1);
        case (mode)
          0:       m_ready = 1'b1;
          1:       m_ready = pat[(cyc - 1) % 7];
          default: m_ready = 1'($urandom_range(0, 1));
        endcase
        if (m_valid && m_ready) begin
          if (q_data.size() == 0) begin
            chk("extra_beat", 64'(m_valid), 64'd0);
          end else begin
            chk("beat_data", 64'(m_data), 64'(q_data[0]));
            chk("beat_addr", 64'(m_addr), 64'(q_addr[0]));
            chk("beat_last", 64'(m_last), 64'(q_last[0]));
            chk("beat_csum", 64'(m_csum), 64'(q_csum[0]));
            void'(q_data.pop_front());
            void'(q_addr.pop_front());
            void'(q_last.pop_front());
            void'(q_csum.pop_front());
            if (q_data.size() == 0) expect_done = 1'b1;
          end
        end
        held   = m_valid && !m_ready;
        h_data = m_data;
        h_addr = m_addr;
        h_last = m_last;
        h_csum = m_csum;
      end
    end
    chk("dump_completed", 64'(finished), 64'd1);
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    m_ready    = 1'b0;
    load_default_rf();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
    chk("rst_csum", 64'(m_csum), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_addr", 64'(m_addr), 64'd0);
    chk("rst_rd_addr", 64'(rf_rd_addr), 64'd0);
    rst = 1'b1;

    // Basic range, full throughput
    run_dump(5'd1, 5'd4, 0, 1'b0);
    // Same range with backpressure; start accepted in the done cycle
    run_dump(5'd1, 5'd4, 1, 1'b0);
    // Wrapping range
    run_dump(5'd30, 5'd1, 0, 1'b0);
    // Single beat, start pulsed while busy
    run_dump(5'd5, 5'd5, 1, 1'b1);
    run_dump(5'd5, 5'd5, 2, 1'b1);

    // Reset in the middle of a dump
    first_addr = 5'd1;
    last_addr  = 5'd4;
    start      = 1'b1;
    m_ready    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_beat1", 64'(m_data), 64'h101);
    @(negedge clk);
    chk("abort_beat2", 64'(m_data), 64'h102);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", 64'(m_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_data", 64'(m_data), 64'd0);
    chk("abort_rd_addr", 64'(rf_rd_addr), 64'd0);
    rst = 1'b1;
    run_dump(5'd7, 5'd8, 0, 1'b0);

`ifdef REGDUMP_CSUM_EN
    // Checksum beat over known contents: 0x11 ^ 0x22 ^ 0x44 = 0x77
    rf[1] = 32'h11;
    rf[2] = 32'h22;
    rf[3] = 32'h44;
    run_dump(5'd1, 5'd3, 0, 1'b0);
    run_dump(5'd1, 5'd3, 1, 1'b0);
    load_default_rf();
`endif

    // Randomized contents, ranges and backpressure
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      run_dump(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2, 1'b0);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
